// File: rtl/rob_commit_pkg.sv
// Shared retirement-stage definitions: ROB entry layout, CDB payload and commit FSM encoding.
// The backtick macros remain for legacy users; new code should use the package localparams.
`ifndef SYS_DEFS_MACROS
`define SYS_DEFS_MACROS
`define XLEN 32
`define ROB_TAG_LEN 4
`define ZERO_REG 5'd0
`define TRUE 1'b1
`define FALSE 1'b0
`endif

package sys_defs;

    localparam int XLEN        = `XLEN;
    localparam int ROB_TAG_LEN = `ROB_TAG_LEN;
    localparam logic [4:0] ZERO_REG = `ZERO_REG;

    typedef struct packed {
        logic            wr_mem;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] address;
    } ROB_ENTRY;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_LEN-1:0] tag;
        logic [XLEN-1:0]        value;
    } CDB_DATA;

    typedef enum logic [1:0] {
        CS_IDLE   = 2'd0,
        CS_ST_REQ = 2'd1,
        CS_ST_ACK = 2'd2
    } COMMIT_STATE;

endpackage

// File: rtl/rob_commit_if.sv
// Store-write channel between the commit stage (master) and the memory system (slave).
// Handshake: a request transfers on a posedge where mem_req_valid && mem_req_ready; while
// valid is high and ready is low, addr/data stay stable. mem_wr_done is a 1-cycle completion pulse.
interface rob_commit_if;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [sys_defs::XLEN-1:0] mem_req_addr;
    logic [sys_defs::XLEN-1:0] mem_req_data;
    logic                      mem_wr_done;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_wr_done
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_wr_done
    );

endinterface

// File: rtl/rob_commit_store_port.sv
// Store side of the commit stage: latches the store, holds the request until accepted,
// then waits for the write-done pulse and reports completion for that single cycle.
module commit_store_port
    import sys_defs::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    rob_commit_if.master    mem,
    output logic            done_o,
    output logic            busy_o,
    output COMMIT_STATE     state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    valid_d = 1'b1;
                    addr_d  = addr_i;
                    data_d  = data_i;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    valid_d = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // Completion pulses are only meaningful here; elsewhere they are ignored.
                if (mem.mem_wr_done) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem.mem_req_valid = valid_q;
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_data  = data_q;
    assign busy_o            = (state_q != S_IDLE);
    assign state_o           = COMMIT_STATE'(state_q);

endmodule

// File: rtl/rob_commit.sv
// In-order retirement stage: retires non-stores in one cycle (RF write + map-table clear),
// hands stores to the store port and retires them on write completion; counts retirements.
module rob_commit
    import sys_defs::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  ROB_ENTRY               head_entry,
    input  logic                   head_ready,
    input  logic [ROB_TAG_LEN-1:0] head_tag,
    rob_commit_if.master           mem,
    output logic                   retire,
    output logic                   rf_wr_en,
    output logic [4:0]             rf_wr_idx,
    output logic [XLEN-1:0]        rf_wr_data,
    output logic                   mt_clear_en,
    output logic [ROB_TAG_LEN-1:0] mt_clear_tag,
    output logic                   store_busy,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output COMMIT_STATE            commit_state
);

    logic                   idle_ready;
    logic                   alu_go;
    logic                   store_start;
    logic                   store_done;
    logic                   writes_reg;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Reset gates decode so nothing retires while reset is held, even with a ready head.
    assign idle_ready  = reset && !store_busy && head_ready;
    assign alu_go      = idle_ready && !head_entry.wr_mem;
    assign store_start = idle_ready &&  head_entry.wr_mem;
    assign writes_reg  = alu_go && (head_entry.dest_reg != ZERO_REG);

    commit_store_port u_store_port (
        .clock   (clock),
        .reset   (reset),
        .start_i (store_start),
        .addr_i  (head_entry.address),
        .data_i  (head_entry.value),
        .mem     (mem),
        .done_o  (store_done),
        .busy_o  (store_busy),
        .state_o (commit_state)
    );

    assign retire       = alu_go || store_done;
    assign rf_wr_en     = writes_reg;
    assign mt_clear_en  = writes_reg;
    assign rf_wr_idx    = alu_go ? head_entry.dest_reg : 5'd0;
    assign rf_wr_data   = alu_go ? head_entry.value    : '0;
    assign mt_clear_tag = alu_go ? head_tag            : '0;

    assign count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, retire};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign retired_count = count_q;

endmodule
